// File: rtl/rgb_hsv_operand_pipe_if.sv
// rtl/rgb_hsv_operand_pipe_if.sv - pixel-in / hue-operand-out stream bundle
// master drives pixels and downstream ready; slave is the operand pipe.
interface rgb_hsv_operand_pipe_if #(
  parameter int DATA_W   = 16,
  parameter int CH_WIDTH = 8
);
  logic [DATA_W-1:0]          i_data;
  logic                       i_valid;
  logic                       i_sof;
  logic                       o_ready;
  logic signed [CH_WIDTH:0]   o_dividend;
  logic [CH_WIDTH-1:0]        o_divisor;
  logic [CH_WIDTH-1:0]        o_value;
  logic [1:0]                 o_function;
  logic                       o_sof;
  logic                       o_valid;
  logic                       i_ready;

  modport master (
    output i_data, i_valid, i_sof, i_ready,
    input  o_ready, o_dividend, o_divisor, o_value, o_function, o_sof, o_valid
  );

  modport slave (
    input  i_data, i_valid, i_sof, i_ready,
    output o_ready, o_dividend, o_divisor, o_value, o_function, o_sof, o_valid
  );
endinterface

// File: rtl/rgb_hsv_operand_pipe.sv
// rtl/rgb_hsv_operand_pipe.sv - two-stage RGB to hue-operand pipeline with valid/ready
// Stage 1 expands and ranks channels, stage 2 forms divisor, dividend and sector code.
module rgb_hsv_operand_pipe #(
  parameter int R_BITS    = 5,
  parameter int G_BITS    = 6,
  parameter int B_BITS    = 5,
  parameter int CH_WIDTH  = 8,
  parameter int REPLICATE = 0
) (
  input logic                   i_clk,
  input logic                   i_rst,
  rgb_hsv_operand_pipe_if.slave bus
);

  typedef struct packed {
    logic                sof;
    logic [1:0]          sel;
    logic [CH_WIDTH-1:0] r;
    logic [CH_WIDTH-1:0] g;
    logic [CH_WIDTH-1:0] b;
    logic [CH_WIDTH-1:0] mx;
    logic [CH_WIDTH-1:0] mn;
  } s1_t;

  typedef struct packed {
    logic                sof;
    logic [1:0]          func;
    logic [CH_WIDTH:0]   dividend;
    logic [CH_WIDTH-1:0] divisor;
    logic [CH_WIDTH-1:0] value;
  } s2_t;

  // Left-align the field; replication ORs in right-shifted copies to fill the low bits.
  function automatic logic [CH_WIDTH-1:0] expand(input logic [CH_WIDTH-1:0] f, input int w);
    logic [CH_WIDTH-1:0] a;
    logic [CH_WIDTH-1:0] e;
    a = f << (CH_WIDTH - w);
    e = a;
    if (REPLICATE != 0) begin
      for (int k = 1; k * w < CH_WIDTH; k++) begin
        e = e | (a >> (k * w));
      end
    end
    return e;
  endfunction

  logic                s1_valid_q, s1_valid_d;
  logic                s2_valid_q, s2_valid_d;
  s1_t                 s1_q, s1_d;
  s2_t                 s2_q, s2_d;
  logic                s1_load, s2_load, accept;
  logic [CH_WIDTH-1:0] r_x, g_x, b_x, diff;
  logic [CH_WIDTH:0]   dvd;

  // A stage may load when empty or when its contents leave this cycle.
  always_comb begin
    s2_load = !s2_valid_q || bus.i_ready;
    s1_load = !s1_valid_q || s2_load;
    accept  = bus.i_valid && s1_load && !i_rst;
  end

  always_comb begin
    r_x = expand(CH_WIDTH'(bus.i_data[R_BITS-1:0]), R_BITS);
    g_x = expand(CH_WIDTH'(bus.i_data[R_BITS +: G_BITS]), G_BITS);
    b_x = expand(CH_WIDTH'(bus.i_data[R_BITS+G_BITS +: B_BITS]), B_BITS);
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_d.sof = bus.i_sof;
      s1_d.r   = r_x;
      s1_d.g   = g_x;
      s1_d.b   = b_x;
      if (r_x >= g_x && r_x >= b_x) begin
        s1_d.sel = 2'd1;
        s1_d.mx  = r_x;
      end else if (g_x >= b_x) begin
        s1_d.sel = 2'd2;
        s1_d.mx  = g_x;
      end else begin
        s1_d.sel = 2'd3;
        s1_d.mx  = b_x;
      end
      s1_d.mn = (r_x <= g_x) ? r_x : g_x;
      if (b_x < s1_d.mn) begin
        s1_d.mn = b_x;
      end
    end
  end

  always_comb begin
    diff = s1_q.mx - s1_q.mn;
    case (s1_q.sel)
      2'd1:    dvd = {1'b0, s1_q.g} - {1'b0, s1_q.b};
      2'd2:    dvd = {1'b0, s1_q.b} - {1'b0, s1_q.r};
      default: dvd = {1'b0, s1_q.r} - {1'b0, s1_q.g};
    endcase
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_load && s1_valid_q) begin
      s2_d.sof     = s1_q.sof;
      s2_d.divisor = diff;
      s2_d.value   = s1_q.mx;
      if (diff == '0) begin
        s2_d.func     = 2'd0;
        s2_d.dividend = '0;
      end else begin
        s2_d.func     = s1_q.sel;
        s2_d.dividend = dvd;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.o_ready    = s1_load && !i_rst;
  assign bus.o_valid    = s2_valid_q;
  assign bus.o_sof      = s2_q.sof;
  assign bus.o_dividend = s2_q.dividend;
  assign bus.o_divisor  = s2_q.divisor;
  assign bus.o_value    = s2_q.value;
  assign bus.o_function = s2_q.func;

endmodule

// File: tb/tb_rgb_hsv_operand_pipe.sv
// tb/tb_rgb_hsv_operand_pipe.sv - scoreboard bench for the RGB hue-operand pipe
// dut0 uses default parameters; dut1 (REPLICATE=1) shadows the same input stream.
module tb_rgb_hsv_operand_pipe;

  typedef struct packed {
    logic       sof;
    logic [8:0] dvd;
    logic [7:0] dvs;
    logic [7:0] val;
    logic [1:0] fn;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  rgb_hsv_operand_pipe_if #(.DATA_W(16), .CH_WIDTH(8)) bus0 ();
  rgb_hsv_operand_pipe_if #(.DATA_W(16), .CH_WIDTH(8)) bus1 ();

  always #5 clk = ~clk;

  assign bus1.i_data  = bus0.i_data;
  assign bus1.i_valid = bus0.i_valid;
  assign bus1.i_sof   = bus0.i_sof;
  assign bus1.i_ready = 1'b1;

  rgb_hsv_operand_pipe #(.REPLICATE(0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0.slave));
  rgb_hsv_operand_pipe #(.REPLICATE(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));

  // Reference: zero-fill expansion, priority expressed as strict wins over red.
  function automatic exp_t model(input logic [15:0] d, input logic sof);
    int r, g, b, mx, mn, dv;
    exp_t e;
    r = int'(d[4:0]) * 8;
    g = int'(d[10:5]) * 4;
    b = int'(d[15:11]) * 8;
    mx = r; dv = g - b; e.fn = 2'd1;
    if (g > r && g >= b) begin
      mx = g; dv = b - r; e.fn = 2'd2;
    end else if (b > r && b > g) begin
      mx = b; dv = r - g; e.fn = 2'd3;
    end
    mn = r;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    if (mx == mn) begin
      e.fn = 2'd0; dv = 0;
    end
    e.sof = sof;
    e.dvd = 9'(dv);
    e.dvs = 8'(mx - mn);
    e.val = 8'(mx);
    return e;
  endfunction

  function automatic exp_t obs0();
    return {bus0.o_sof, bus0.o_dividend, bus0.o_divisor, bus0.o_value, bus0.o_function};
  endfunction

  function automatic exp_t obs1();
    return {bus1.o_sof, bus1.o_dividend, bus1.o_divisor, bus1.o_value, bus1.o_function};
  endfunction

  task automatic drive(input logic v, input logic [15:0] d, input logic s, input logic rdy);
    bus0.i_valid = v;
    bus0.i_data  = d;
    bus0.i_sof   = s;
    bus0.i_ready = rdy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus0.o_valid, obs0()} !== 30'd0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0", {bus0.o_valid, obs0()});
    end
    n_cmp++;
    if (bus0.o_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready got %b want 0", bus0.o_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus0.o_ready !== 1'b1 || bus0.o_valid !== 1'b0) begin
      n_bad++; $display("FAIL post_reset got rdy=%b vld=%b want rdy=1 vld=0", bus0.o_ready, bus0.o_valid);
    end
  endtask

  task automatic test_directed;
    logic [15:0] dd [5];
    exp_t        ee [5];
    dd = '{16'h001F, 16'h07E0, 16'hF800, 16'hFFFF, 16'hA01F};
    ee[0] = '{1'b0, 9'd0,   8'd248, 8'd248, 2'd1};
    ee[1] = '{1'b0, 9'd0,   8'd252, 8'd252, 2'd2};
    ee[2] = '{1'b0, 9'd0,   8'd248, 8'd248, 2'd3};
    ee[3] = '{1'b0, 9'd0,   8'd4,   8'd252, 2'd2};
    ee[4] = '{1'b0, 9'h160, 8'd248, 8'd248, 2'd1};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1 drive(1'b1, dd[k], 1'b0, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (bus0.o_ready !== 1'b1) begin
        n_bad++; $display("FAIL dir_ready[%0d] got %b want 1", k, bus0.o_ready);
      end
      @(posedge clk); #1 drive(1'b0, 16'h0, 1'b0, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (bus0.o_valid !== 1'b0) begin
        n_bad++; $display("FAIL dir_early[%0d] got vld=%b want 0", k, bus0.o_valid);
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (bus0.o_valid !== 1'b1 || obs0() !== ee[k]) begin
        n_bad++; $display("FAIL dir_out[%0d] got vld=%b %h want vld=1 %h", k, bus0.o_valid, obs0(), ee[k]);
      end
      if (k == 3) begin
        n_cmp++;
        if (bus1.o_valid !== 1'b1 || obs1() !== exp_t'({1'b0, 9'd0, 8'd0, 8'd255, 2'd0})) begin
          n_bad++; $display("FAIL achromatic got vld=%b %h want vld=1 %h", bus1.o_valid, obs1(),
                            exp_t'({1'b0, 9'd0, 8'd0, 8'd255, 2'd0}));
        end
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (bus0.o_valid !== 1'b0) begin
        n_bad++; $display("FAIL dir_dup[%0d] got vld=%b want 0", k, bus0.o_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] px [20];
    int          next_in, got, c;
    logic        rdy;
    for (int i = 0; i < 20; i++) px[i] = 16'($urandom);
    next_in = 0; got = 0; c = 0;
    exp_q.delete();
    while (got < 20 && c < 600) begin
      @(posedge clk); #1;
      rdy = (c < 3) ? 1'b0 : 1'($urandom_range(0, 1));
      if (next_in < 20 && (c < 3 || $urandom_range(0, 3) != 0))
        drive(1'b1, px[next_in], next_in == 0, rdy);
      else
        drive(1'b0, 16'($urandom), 1'($urandom), rdy);
      @(negedge clk);
      if (c == 2) begin
        n_cmp++;
        if (bus0.o_ready !== 1'b0) begin
          n_bad++; $display("FAIL capacity got rdy=%b want 0", bus0.o_ready);
        end
      end
      if (bus0.o_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL bp_spurious got %h want no output", obs0());
        end else if (obs0() !== exp_q[0]) begin
          n_bad++; $display("FAIL bp_pixel[%0d] got %h want %h", got, obs0(), exp_q[0]);
        end
        if (bus0.i_ready === 1'b1 && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      if (bus0.i_valid === 1'b1 && bus0.o_ready === 1'b1) begin
        exp_q.push_back(model(bus0.i_data, bus0.i_sof));
        next_in++;
      end
      c++;
    end
    n_cmp++;
    if (got != 20 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL bp_count got %0d left %0d want 20 left 0", got, exp_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 drive(1'b0, 16'h0, 1'b0, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (bus0.o_valid !== 1'b0) begin
        n_bad++; $display("FAIL bp_extra got vld=%b want 0", bus0.o_valid);
      end
    end
  endtask

  task automatic test_reset_midstream;
    exp_q.delete();
    @(posedge clk); #1 drive(1'b1, 16'h001F, 1'b1, 1'b0);
    @(posedge clk); #1 drive(1'b1, 16'hF800, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b1; drive(1'b0, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus0.o_ready !== 1'b0 || bus0.o_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_inflight got rdy=%b vld=%b want rdy=0 vld=1", bus0.o_ready, bus0.o_valid);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus0.o_valid !== 1'b0 || bus0.o_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_flush got vld=%b rdy=%b want vld=0 rdy=1", bus0.o_valid, bus0.o_ready);
    end
    @(posedge clk); #1 drive(1'b1, 16'h07E0, 1'b0, 1'b1);
    @(negedge clk);
    if (bus0.i_valid === 1'b1 && bus0.o_ready === 1'b1) exp_q.push_back(model(bus0.i_data, bus0.i_sof));
    @(posedge clk); #1 drive(1'b0, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus0.o_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_stale got vld=%b want 0", bus0.o_valid);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 1 || bus0.o_valid !== 1'b1 || obs0() !== exp_q[0]) begin
      n_bad++; $display("FAIL rst_next got vld=%b %h want vld=1 %h", bus0.o_valid, obs0(),
                        model(16'h07E0, 1'b0));
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (bus0.o_valid !== 1'b0) begin
        n_bad++; $display("FAIL rst_tail got vld=%b want 0", bus0.o_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_hsv_operand_pipe.md
# rgb_hsv_operand_pipe

Parametrised, pipelined successor to the pixel-to-HSV operand decoder in the colour-detect path. Accepts packed RGB pixels of configurable channel widths, expands each channel to a common width, and produces the hue dividend/divisor pair, hue-sector code, value (max channel) and an achromatic flag. It adds valid/ready backpressure and a start-of-frame sideband, and sits between the camera pixel unpacker and the hue divider.

## Interface
Parameters:
- R_BITS, 5, red field width; red occupies `i_data[R_BITS-1:0]`.
- G_BITS, 6, green field width; green occupies the next G_BITS bits.
- B_BITS, 5, blue field width; blue occupies the top B_BITS bits.
- CH_WIDTH, 8, expanded channel width; must be >= each field width.
- REPLICATE, 0, expansion mode:
  - 0: left-shift and zero-fill (31 -> 248).
  - 1: MSB replication (31 -> 255).

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, reset. Synchronous, active-high.
- i_data, in, R_BITS+G_BITS+B_BITS, packed pixel.
- i_valid, in, 1, input pixel valid.
- i_sof, in, 1, start-of-frame marker. Qualified by i_valid.
- o_ready, out, 1, input accepted when `i_valid & o_ready`.
- o_dividend, out, CH_WIDTH+1, signed hue numerator.
- o_divisor, out, CH_WIDTH, unsigned max−min.
- o_value, out, CH_WIDTH, max channel.
- o_function, out, 2, hue sector:
  - 0: achromatic.
  - 1: red max.
  - 2: green max.
  - 3: blue max.
- o_sof, out, 1, sof of the output pixel.
- o_valid, out, 1, output valid.
- i_ready, in, 1, downstream accept. Transfer occurs on `o_valid & i_ready`.

## Operation
- Stage 1 (expand/compare):
  - Expand R, G, B to CH_WIDTH per REPLICATE.
  - Compute max, min and the max-channel select.
  - Tie priority: red > green > blue.
    - Red wins when r>=g and r>=b.
    - Otherwise green wins when g>=b.
    - Otherwise blue wins.
- Stage 2 (subtract):
  - divisor = max − min. Unsigned, cannot underflow.
  - value = max.
  - Dividend, sign-extended to CH_WIDTH+1 two's complement:
    - red max: g − b.
    - green max: b − r.
    - blue max: r − g.
  - If divisor == 0, then o_function = 0 and o_dividend = 0, regardless of the select.
  - Otherwise o_function = 1/2/3 per the select.
- Sideband: i_sof travels with its pixel through both stages unchanged.
- Each stage has its own valid bit.
- Stage loading:
  - A stage loads when it is empty or when its contents move forward in the same cycle.
  - The output stage's contents move forward when `o_valid & i_ready`.
  - Stage 1 empties forward into stage 2.
- Bubbles collapse: a stall holds only the stages that are full.
- o_ready = stage-1 empty, or stage 1 advancing this cycle. o_ready is combinational from i_ready and the valid bits.
- While `o_valid & !i_ready`, all outputs hold stable.
- Reset:
  - In the cycle i_rst is sampled high, all valid bits clear.
  - o_valid, o_sof, o_dividend, o_divisor, o_value and o_function reset to 0.
  - In-flight pixels are discarded, with no partial output.
  - o_ready is 0 while i_rst is high.
  - o_ready is 1 in the first cycle after reset deasserts.

## Timing
- Latency: 2 cycles. A pixel accepted on edge N is presented with o_valid=1 after edge N+2.
- Throughput: 1 pixel/cycle with i_ready held high.
- Capacity: 2 pixels buffered. With i_ready low, o_ready drops after 2 accepts and stays low until a transfer.
- Simultaneous accept and transfer with the pipe full: both occur in the same cycle. No bubble and no loss.
- i_data and i_sof are ignored when i_valid=0 or o_ready=0.
- Boundary ranges:
  - Dividend range is ±(2^CH_WIDTH − 1), so it needs no saturation.
  - Divisor range is 0..2^CH_WIDTH − 1.

## Test plan
All cases use default parameters unless a different REPLICATE is stated.
- Red-max: i_data=16'h001F -> function=1, dividend=0, divisor=248, value=248 two cycles later.
- Green-max: i_data=16'h07E0 -> function=2, dividend=0, divisor=252.
- Blue-max: i_data=16'hF800 -> function=3, dividend=0, divisor=248.
- Tie: i_data=16'hFFFF -> function=2, dividend=0, divisor=4, value=252.
- Achromatic: i_data=16'hFFFF with REPLICATE=1 -> function=0, dividend=0, divisor=0, value=255.
- Negative dividend: r=31, g=0, b=20 (i_data=16'hA01F) -> function=1, dividend=−160, divisor=248.
- Backpressure:
  - Stimulus: stream 20 random pixels with sof on the first; toggle i_ready pseudo-randomly; check against a reference-model queue.
  - Required response: all 20 pixels emerge in order, none dropped or duplicated, o_sof only on the first, outputs stable while stalled, o_ready=0 after 2 accepts with i_ready low.
- Reset mid-stream:
  - Stimulus: assert i_rst for 1 cycle with 2 pixels in flight.
  - Required response: o_valid=0 on the next cycle, no stale pixel emerges afterward, and the next accepted pixel emerges 2 cycles after acceptance.
